// File: rtl/writeback_queue_pkg.sv
// writeback_queue_pkg: shared widths and entry record for the write-back queue
package writeback_queue_pkg;
  localparam int XLEN_DEF = 64;
  localparam int REGW = 5;
  typedef struct packed {
    logic [REGW-1:0] rd;
    logic [XLEN_DEF-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/wbq_bypass_match.sv
// wbq_bypass_match: youngest-match search over age-ordered queue entries (index 0 oldest)
module wbq_bypass_match
  import writeback_queue_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input logic [REGW-1:0] rs,
  input logic [CW-1:0] vcnt,
  input logic [REGW-1:0] rds [DEPTH],
  input logic [XLEN-1:0] datas [DEPTH],
  output logic hit,
  output logic [XLEN-1:0] data
);
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < vcnt && rs != '0 && rds[i] == rs) begin
        hit = 1'b1;
        data = datas[i];
      end
  end
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: merges ALU and load write-backs into one register-file write port,
// with a pending-write bypass for two read addresses.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  input logic alu_valid,
  input logic [REGW-1:0] alu_rd,
  input logic [XLEN-1:0] alu_data,
  output logic alu_ready,
  input logic mem_valid,
  input logic [REGW-1:0] mem_rd,
  input logic [XLEN-1:0] mem_data,
  output logic mem_ready,
  output logic RegWrite,
  output logic [REGW-1:0] rd,
  output logic [XLEN-1:0] writeData,
  input logic [REGW-1:0] rs1,
  input logic [REGW-1:0] rs2,
  output logic fwd1_hit,
  output logic fwd2_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic [XLEN-1:0] fwd2_data,
  output logic [$clog2(DEPTH):0] count,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt, free;
  logic [REGW-1:0] rd_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [REGW-1:0] ord_rd [DEPTH];
  logic [XLEN-1:0] ord_data [DEPTH];
  logic mem_push, alu_push;
  // Readies depend only on the registered count, so a same-cycle pop never raises them.
  assign free = CW'(DEPTH) - cnt;
  assign mem_ready = !reset && free >= CW'(1);
  assign alu_ready = !reset && free >= CW'(2);
  assign mem_push = mem_valid && mem_ready && mem_rd != '0;
  assign alu_push = alu_valid && alu_ready && alu_rd != '0;
  assign count = reset ? '0 : cnt;
  assign empty = count == '0;
  assign RegWrite = !empty;
  assign rd = RegWrite ? rd_q[head] : '0;
  assign writeData = RegWrite ? data_q[head] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      if (mem_push) begin
        rd_q[tail] <= mem_rd;
        data_q[tail] <= mem_data;
      end
      if (alu_push) begin
        rd_q[tail + PW'(mem_push)] <= alu_rd;
        data_q[tail + PW'(mem_push)] <= alu_data;
      end
      tail <= tail + PW'(mem_push) + PW'(alu_push);
      head <= head + PW'(RegWrite);
      cnt <= cnt + CW'(mem_push) + CW'(alu_push) - CW'(RegWrite);
    end
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ord_rd[i] = rd_q[head + PW'(i)];
      ord_data[i] = data_q[head + PW'(i)];
    end
  end
  wbq_bypass_match #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) u_match1 (
    .rs(rs1), .vcnt(count), .rds(ord_rd), .datas(ord_data), .hit(fwd1_hit), .data(fwd1_data)
  );
  wbq_bypass_match #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) u_match2 (
    .rs(rs2), .vcnt(count), .rds(ord_rd), .datas(ord_data), .hit(fwd2_hit), .data(fwd2_data)
  );
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed vector table plus randomized run against a queue-based model
module tb_writeback_queue;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0] alu_rd = '0, mem_rd = '0, rs1 = '0, rs2 = '0;
  logic [63:0] alu_data = '0, mem_data = '0;
  logic alu_ready, mem_ready, RegWrite, fwd1_hit, fwd2_hit, empty;
  logic [4:0] rd;
  logic [63:0] writeData, fwd1_data, fwd2_data;
  logic [2:0] count;
  int checks = 0;
  int failures = 0;

  writeback_queue #(.XLEN(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .rd(rd), .writeData(writeData),
    .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, av;
    logic [4:0] ard;
    logic [63:0] adat;
    logic mv;
    logic [4:0] mrd;
    logic [63:0] mdat;
    logic [4:0] r1, r2;
    logic ear, emr, erw;
    logic [4:0] erd;
    logic [63:0] ewd;
    logic [2:0] ecnt;
    logic eh1;
    logic [63:0] ed1;
    logic eh2;
    logic [63:0] ed2;
  } vec_t;

  typedef struct {
    logic [4:0] rd;
    logic [63:0] d;
  } ent_t;

  ent_t q[$];
  vec_t v[17];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic check_all(input logic ear, emr, erw, input logic [4:0] erd, input logic [63:0] ewd,
                           input logic [2:0] ecnt, input logic eh1, input logic [63:0] ed1,
                           input logic eh2, input logic [63:0] ed2);
    chk("alu_ready", 64'(alu_ready), 64'(ear));
    chk("mem_ready", 64'(mem_ready), 64'(emr));
    chk("RegWrite", 64'(RegWrite), 64'(erw));
    chk("rd", 64'(rd), 64'(erd));
    chk("writeData", writeData, ewd);
    chk("count", 64'(count), 64'(ecnt));
    chk("empty", 64'(empty), 64'(ecnt == 3'd0));
    chk("fwd1_hit", 64'(fwd1_hit), 64'(eh1));
    chk("fwd1_data", fwd1_data, ed1);
    chk("fwd2_hit", 64'(fwd2_hit), 64'(eh2));
    chk("fwd2_data", fwd2_data, ed2);
  endtask

  function automatic ent_t youngest(input logic [4:0] rs, output logic hit);
    ent_t r = '{5'd0, 64'd0};
    hit = 1'b0;
    for (int i = q.size() - 1; i >= 0 && !hit; i--)
      if (rs != 5'd0 && q[i].rd == rs) begin
        hit = 1'b1;
        r = q[i];
      end
    return r;
  endfunction

  initial begin
    //        rst av ard adat   mv mrd mdat   r1 r2  ar mr rw rd wd     cnt h1 d1     h2 d2
    v[0]  = '{1, 1, 5, 'h2A,  0, 0, 0,     0, 0,  0, 0, 0, 0, 0,     0, 0, 0,     0, 0};
    v[1]  = '{0, 1, 5, 'h2A,  0, 0, 0,     0, 0,  1, 1, 0, 0, 0,     0, 0, 0,     0, 0};
    v[2]  = '{0, 0, 0, 0,     0, 0, 0,     5, 0,  1, 1, 1, 5, 'h2A,  1, 1, 'h2A,  0, 0};
    v[3]  = '{0, 1, 4, 'h22,  1, 3, 'h11,  0, 0,  1, 1, 0, 0, 0,     0, 0, 0,     0, 0};
    v[4]  = '{0, 0, 0, 0,     0, 0, 0,     4, 3,  1, 1, 1, 3, 'h11,  2, 1, 'h22,  1, 'h11};
    v[5]  = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  1, 1, 1, 4, 'h22,  1, 0, 0,     0, 0};
    v[6]  = '{0, 1, 7, 2,     1, 7, 1,     0, 0,  1, 1, 0, 0, 0,     0, 0, 0,     0, 0};
    v[7]  = '{0, 0, 0, 0,     0, 0, 0,     7, 0,  1, 1, 1, 7, 1,     2, 1, 2,     0, 0};
    v[8]  = '{0, 0, 0, 0,     0, 0, 0,     7, 0,  1, 1, 1, 7, 2,     1, 1, 2,     0, 0};
    v[9]  = '{0, 1, 0, 'hFF,  0, 0, 0,     0, 0,  1, 1, 0, 0, 0,     0, 0, 0,     0, 0};
    v[10] = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  1, 1, 0, 0, 0,     0, 0, 0,     0, 0};
    v[11] = '{0, 1, 2, 2,     1, 1, 1,     0, 0,  1, 1, 0, 0, 0,     0, 0, 0,     0, 0};
    v[12] = '{0, 1, 4, 4,     1, 3, 3,     0, 0,  1, 1, 1, 1, 1,     2, 0, 0,     0, 0};
    v[13] = '{0, 1, 6, 6,     1, 5, 5,     3, 1,  0, 1, 1, 2, 2,     3, 1, 3,     0, 0};
    v[14] = '{1, 0, 0, 0,     1, 9, 9,     0, 0,  0, 0, 0, 0, 0,     0, 0, 0,     0, 0};
    v[15] = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  1, 1, 0, 0, 0,     0, 0, 0,     0, 0};
    v[16] = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  1, 1, 0, 0, 0,     0, 0, 0,     0, 0};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      reset = v[i].rst;
      alu_valid = v[i].av; alu_rd = v[i].ard; alu_data = v[i].adat;
      mem_valid = v[i].mv; mem_rd = v[i].mrd; mem_data = v[i].mdat;
      rs1 = v[i].r1; rs2 = v[i].r2;
      #1;
      check_all(v[i].ear, v[i].emr, v[i].erw, v[i].erd, v[i].ewd, v[i].ecnt,
                v[i].eh1, v[i].ed1, v[i].eh2, v[i].ed2);
    end
    for (int c = 0; c < 3000; c++) begin
      int n;
      logic h1, h2, mf, af;
      ent_t y1, y2, hd;
      @(negedge clk);
      reset = (c == 0) || ($urandom_range(0, 63) == 0);
      alu_valid = 1'($urandom_range(0, 1));
      mem_valid = 1'($urandom_range(0, 1));
      alu_rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      mem_rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      alu_data = {$urandom, $urandom};
      mem_data = {$urandom, $urandom};
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      #1;
      n = q.size();
      y1 = youngest(rs1, h1);
      y2 = youngest(rs2, h2);
      hd = (n > 0) ? q[0] : '{5'd0, 64'd0};
      if (reset)
        check_all(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      else
        check_all(DEPTH - n >= 2, DEPTH - n >= 1, n > 0, hd.rd, hd.d, 3'(n), h1, y1.d, h2, y2.d);
      if (reset) q.delete();
      else begin
        mf = mem_valid && (DEPTH - n >= 1);
        af = alu_valid && (DEPTH - n >= 2);
        if (n > 0) void'(q.pop_front());
        if (mf && mem_rd != 5'd0) q.push_back('{mem_rd, mem_data});
        if (af && alu_rd != 5'd0) q.push_back('{alu_rd, alu_data});
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
